// File: rtl/lcd_reader_pkg.sv
// Shared definitions for the HD44780 4-bit LCD read and write engines:
// FSM encoding, controller timing in ns at a 50 MHz clock, busy-flag position.
package lcd_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OWN    = 3'd1,
        S_SETUP  = 3'd2,
        S_E_HIGH = 3'd3,
        S_HOLD   = 3'd4,
        S_GAP    = 3'd5,
        S_FIN    = 3'd6
    } lcd_state_t;

    localparam int CLK_HZ     = 50_000_000;
    localparam int NS_PER_CLK = 1_000_000_000 / CLK_HZ;

    localparam int T_AS_NS  = 60;
    localparam int T_PW_NS  = 450;
    localparam int T_DDR_NS = 360;
    localparam int T_AH_NS  = 20;
    localparam int T_GAP_NS = 1000;

    localparam int BF_BIT = 7;

    function automatic int ns_to_cycles(input int ns);
        return (ns + NS_PER_CLK - 1) / NS_PER_CLK;
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter with a zero flag, used to time LCD strobe phases.
// A load of N gives N+1 cycles before o_zero rises; the counter then holds at zero.
module lcd_delay_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// 4-bit HD44780 read engine: one byte as two E-pulsed nibbles (high first), optional BF polling.
// Non-poll read completes 2 + 2*(T_SETUP+T_EPW+T_HOLD+T_GAP) cycles after start; start ignored while busy.
module lcd_reader
    import lcd_reader_pkg::*;
#(
    parameter int T_SETUP  = 3,
    parameter int T_EPW    = 24,
    parameter int T_HOLD   = 2,
    parameter int T_GAP    = 50,
    parameter int POLL_MAX = 20000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rs_sel,
    input  logic       i_poll,
    input  logic [3:0] i_lcd_din,
    output logic       o_lcd_rs,
    output logic       o_lcd_w,
    output logic       o_lcd_e,
    output logic       o_bus_own,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rd_data,
    output logic       o_timeout
);

    localparam int CNT_W = 16;
    localparam int PC_W  = $clog2(POLL_MAX + 1);

    lcd_state_t      r_state;
    logic            r_lcd_rs;
    logic            r_lcd_w;
    logic            r_lcd_e;
    logic            r_bus_own;
    logic            r_busy;
    logic            r_done;
    logic [7:0]      r_rd_data;
    logic            r_timeout;
    logic            r_rs_lat;
    logic            r_poll;
    logic            r_nibble;
    logic [PC_W-1:0] r_poll_cnt;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_zero;
    logic             w_bf;

    assign w_bf = r_rd_data[BF_BIT];

    // The counter is reloaded on every transition into a timed phase with that phase's length.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        case (r_state)
            S_OWN: begin
                w_cnt_load = 1'b1;
                w_cnt_val  = CNT_W'(T_SETUP - 1);
            end
            S_SETUP: begin
                w_cnt_load = w_cnt_zero;
                w_cnt_val  = CNT_W'(T_EPW - 1);
            end
            S_E_HIGH: begin
                w_cnt_load = w_cnt_zero;
                w_cnt_val  = CNT_W'(T_HOLD - 1);
            end
            S_HOLD: begin
                w_cnt_load = w_cnt_zero;
                w_cnt_val  = CNT_W'(T_GAP - 1);
            end
            S_GAP: begin
                w_cnt_load = w_cnt_zero;
                w_cnt_val  = CNT_W'(T_SETUP - 1);
            end
            default: begin
                w_cnt_load = 1'b0;
                w_cnt_val  = '0;
            end
        endcase
    end

    lcd_delay_cnt #(
        .W(CNT_W)
    ) u_delay (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_cnt_load),
        .i_val  (w_cnt_val),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_lcd_rs   <= 1'b0;
            r_lcd_w    <= 1'b0;
            r_lcd_e    <= 1'b0;
            r_bus_own  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_data  <= 8'h00;
            r_timeout  <= 1'b0;
            r_rs_lat   <= 1'b0;
            r_poll     <= 1'b0;
            r_nibble   <= 1'b0;
            r_poll_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rs_lat   <= i_rs_sel & ~i_poll;
                        r_poll     <= i_poll;
                        r_timeout  <= 1'b0;
                        r_poll_cnt <= '0;
                        r_nibble   <= 1'b0;
                        r_bus_own  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_OWN;
                    end
                end
                S_OWN: begin
                    r_lcd_rs <= r_rs_lat;
                    r_lcd_w  <= 1'b1;
                    r_state  <= S_SETUP;
                end
                S_SETUP: begin
                    if (w_cnt_zero) begin
                        r_lcd_e <= 1'b1;
                        r_state <= S_E_HIGH;
                    end
                end
                S_E_HIGH: begin
                    if (w_cnt_zero) begin
                        if (r_nibble) begin
                            r_rd_data[3:0] <= i_lcd_din;
                        end else begin
                            r_rd_data[7:4] <= i_lcd_din;
                        end
                        r_lcd_e <= 1'b0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_zero) begin
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_cnt_zero) begin
                        if (!r_nibble) begin
                            r_nibble <= 1'b1;
                            r_state  <= S_SETUP;
                        end else if (r_poll && w_bf && (r_poll_cnt < PC_W'(POLL_MAX - 1))) begin
                            r_poll_cnt <= r_poll_cnt + PC_W'(1);
                            r_nibble   <= 1'b0;
                            r_state    <= S_SETUP;
                        end else begin
                            // Still busy here in poll mode means the read budget ran out.
                            r_timeout <= r_poll & w_bf;
                            r_lcd_w   <= 1'b0;
                            r_lcd_rs  <= 1'b0;
                            r_done    <= 1'b1;
                            r_bus_own <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_lcd_rs  = r_lcd_rs;
    assign o_lcd_w   = r_lcd_w;
    assign o_lcd_e   = r_lcd_e;
    assign o_bus_own = r_bus_own;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rd_data = r_rd_data;
    assign o_timeout = r_timeout;

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- 4-bit HD44780-style LCD read engine. It is the read-side counterpart of the LCD write driver.
- Performs one byte read as two E-pulsed nibble reads, high nibble first. The byte is either the busy-flag/address-counter byte (RS=0) or the DDRAM/CGRAM data byte (RS=1).
- Optional poll mode repeats busy-flag reads until BF=0.
- Sits beside the write driver. The top level muxes LCD_RS/LCD_W/LCD_E using bus_own, and tristates the FPGA data drivers while bus_own=1.

Parameters:
- T_SETUP, 3, clk cycles from RS/W valid to E rise (tAS).
- T_EPW, 24, clk cycles E held high (covers PW ≥ 450 ns and tDDR at 50 MHz).
- T_HOLD, 2, clk cycles from E fall to the next RS/W change (tAH).
- T_GAP, 50, clk cycles E low between nibbles and between poll reads (≥ 1 µs).
- POLL_MAX, 20000, maximum busy-flag reads in poll mode before timeout.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle request. Accepted only in IDLE.
- rs_sel, in, 1, RS value for the read. Sampled with start.
- poll, in, 1, 1 = repeat BF reads until BF=0. Sampled with start; forces RS=0.
- lcd_din, in, 4, LCD DB7..DB4 read back from the pins.
- LCD_RS, out, 1, register select.
- LCD_W, out, 1, 1 = read.
- LCD_E, out, 1, enable strobe.
- bus_own, out, 1, reader owns the LCD bus; FPGA data drivers must be off.
- busy, out, 1, transaction in progress.
- done, out, 1, one-cycle pulse when rd_data is valid.
- rd_data, out, 8, last byte read.
- timeout, out, 1, sticky; set on poll overflow, cleared by the next accepted start.

Behaviour:
- Reset, applied asynchronously at any time including mid-transaction:
  - state=IDLE.
  - LCD_E=0, LCD_W=0, LCD_RS=0.
  - bus_own=0, busy=0, done=0, rd_data=8'h00, timeout=0.
  - All counters cleared.
- All outputs are registered.
- FSM states: IDLE, OWN, SETUP, E_HIGH, HOLD, GAP, FIN.
- IDLE:
  - On start: latch rs_sel (RS=0 if poll), latch poll, clear timeout and poll count.
  - Set bus_own=1 and busy=1, then go to OWN.
  - start while busy is ignored.
- OWN (1 cycle): drive LCD_RS; set LCD_W=1; go to SETUP. This gives the bus a dead cycle after the FPGA drivers are released.
- SETUP: wait T_SETUP cycles, then set LCD_E=1 and go to E_HIGH.
- E_HIGH:
  - Lasts T_EPW cycles.
  - On the last cycle, capture lcd_din into rd_data[7:4] on nibble 0, or rd_data[3:0] on nibble 1.
  - Then set LCD_E=0 and go to HOLD.
- HOLD: T_HOLD cycles, then go to GAP.
- GAP (T_GAP cycles), exit depends on nibble and mode:
  - After nibble 0: nibble=1, go to SETUP. RS and W stay unchanged.
  - After nibble 1, poll=1, BF (rd_data[7]) = 1, poll count < POLL_MAX−1: increment count, nibble=0, go to SETUP.
  - After nibble 1, poll=1, count reaches POLL_MAX−1 with BF still 1: set timeout=1, go to FIN.
  - Otherwise: go to FIN.
- FIN (1 cycle): LCD_W=0, LCD_RS=0, done=1, bus_own=0, busy=0, then go to IDLE. done is asserted only in FIN.
- The captured byte is always exactly two nibbles. rd_data holds its value until the next capture.
- LCD_E must never be high while LCD_W=0.
- LCD_RS/LCD_W change only when LCD_E=0 and at least T_HOLD cycles after E fell.
- Latency of a non-poll read: 1 + 2·(T_SETUP+T_EPW+T_HOLD+T_GAP) + 1 cycles from start to done.

Decomposition:
- Shared LCD package holds:
  - the FSM state encoding;
  - HD44780 timing constants (in ns) and a cycles-per-ns helper constant for a 50 MHz clk;
  - the BF bit index (7).
- One sub-module, lcd_delay_cnt: loadable down-counter with a zero flag. It is reused by the write driver for the same strobe timing.

Test Plan:
- Reset, then start with rs_sel=1, poll=0; LCD model returns 8'hA5:
  - exactly 2 E pulses, each 24 cycles wide;
  - LCD_W=1 throughout;
  - done after 1+2·79+1=160 cycles;
  - rd_data=8'hA5, timeout=0.
- poll=1; model returns BF=1 for 3 reads, then 8'h0C:
  - 8 E pulses;
  - LCD_RS=0 throughout;
  - rd_data=8'h0C;
  - single done pulse.
- POLL_MAX overridden to 4, model stuck at BF=1:
  - 4 reads (8 E pulses);
  - done with timeout=1;
  - next start clears timeout.
- rst asserted in the middle of nibble 1's E_HIGH:
  - LCD_E, LCD_W and bus_own drop the same cycle, asynchronously;
  - rd_data=8'h00;
  - a new start completes normally.
- start pulsed repeatedly while busy:
  - ignored; a single transaction, a single done.
- Protocol checker, all tests:
  - E never high with W=0;
  - RS/W stable from ≥T_SETUP before E rise to ≥T_HOLD after E fall;
  - bus_own=1 at least one cycle before LCD_W rises.
